// File: rtl/autocorr_frame_seq.sv
// -----------------------------------------------------------------------------
// autocorr_frame_seq
//
// Frame sequencer for the autocorrelation/windowing datapath. The block
// collects FRAME_LEN speech samples into the engine's input memory and pulses
// `start`. It then waits for `done` and reads the NUM_R autocorrelation results
// back through the test-read port. The results go out on a valid/ready stream.
//
// Ports
//   clk, reset           system clock; asynchronous active-low reset
//   run                  level; keeps the sequencer processing frames back to back
//   sampleIn/Valid/Ready 16-bit signed sample stream input
//   xMemAddr/Out/En      input-memory write port (data sign-extended to 32 bits)
//   autocorrMuxSel       1 = sequencer owns the memory ports, 0 = engine owns them
//   start, done          one-cycle engine start pulse; engine completion level
//   testReadRequested    result read address (R_BASE + index)
//   memIn                result read data, valid RD_LAT cycles after the address
//   rOut/rIndex/rValid/rReady  result stream output
//   busy                 high in every state except IDLE
//   error                WAIT watchdog fired on the current frame
//
// Optional feature
//   AUTOCORR_SEQ_TIMEOUT_EN : when defined, a counter bounds WAIT to
//   TIMEOUT_CYC cycles. If it expires, `error` is raised and the frame ends
//   without a read-back. When undefined, WAIT is unbounded and `error` is
//   tied low.
// -----------------------------------------------------------------------------
module autocorr_frame_seq #(
    parameter int          FRAME_LEN   = 240,
    parameter int          NUM_R       = 11,
    parameter logic [11:0] R_BASE      = 12'd0,
    parameter int          RD_LAT      = 2,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] sampleIn,
    input  logic        sampleValid,
    output logic        sampleReady,
    output logic [7:0]  xMemAddr,
    output logic [31:0] xMemOut,
    output logic        xMemEn,
    output logic        autocorrMuxSel,
    output logic        start,
    input  logic        done,
    output logic [11:0] testReadRequested,
    input  logic [31:0] memIn,
    output logic [31:0] rOut,
    output logic [3:0]  rIndex,
    output logic        rValid,
    input  logic        rReady,
    output logic        busy,
    output logic        error
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_R - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, OUT} stateT;

    stateT             state;
    logic [CNT_W-1:0]  sampleCount;   // samples accepted in the current frame
    logic [LAT_W-1:0]  latCount;      // cycles spent in READ for the current word
    logic [3:0]        idx;           // result index being read / presented

`ifdef AUTOCORR_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] waitCount;
`else
    assign error = 1'b0;
`endif

    // NOTE: all state and outputs live in this single clocked block and use
    // non-blocking assignments, so every output is a flop and reads in the same
    // block see the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            sampleCount       <= '0;
            latCount          <= '0;
            idx               <= '0;
            sampleReady       <= 1'b0;
            xMemAddr          <= '0;
            xMemOut           <= '0;
            xMemEn            <= 1'b0;
            autocorrMuxSel    <= 1'b1;
            start             <= 1'b0;
            testReadRequested <= '0;
            rOut              <= '0;
            rIndex            <= '0;
            rValid            <= 1'b0;
            busy              <= 1'b0;
`ifdef AUTOCORR_SEQ_TIMEOUT_EN
            waitCount         <= '0;
            error             <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes; only the cycles that need them set them.
            xMemEn <= 1'b0;
            start  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (run) begin
                        state          <= LOAD;
                        busy           <= 1'b1;
                        sampleReady    <= 1'b1;
                        sampleCount    <= '0;
                        autocorrMuxSel <= 1'b1;
                    end
                end

                LOAD: begin
                    if (sampleValid && sampleReady) begin
                        xMemEn      <= 1'b1;
                        xMemAddr    <= 8'(sampleCount);
                        xMemOut     <= {{16{sampleIn[15]}}, sampleIn};
                        sampleCount <= sampleCount + 1'b1;
                        if (sampleCount == CNT_LAST) begin
                            sampleReady <= 1'b0;
                        end
`ifdef AUTOCORR_SEQ_TIMEOUT_EN
                        error       <= 1'b0;
`endif
                    end else if (sampleCount == CNT_FULL) begin
                        // The last write is on the bus this cycle; hand the
                        // memory to the engine on the same edge as start.
                        state          <= START;
                        start          <= 1'b1;
                        autocorrMuxSel <= 1'b0;
                    end
                end

                START: begin
                    state <= WAIT;
`ifdef AUTOCORR_SEQ_TIMEOUT_EN
                    waitCount <= '0;
`endif
                end

                WAIT: begin
                    if (done) begin
                        state             <= READ;
                        idx               <= '0;
                        latCount          <= '0;
                        autocorrMuxSel    <= 1'b1;
                        testReadRequested <= R_BASE;
                    end
`ifdef AUTOCORR_SEQ_TIMEOUT_EN
                    else if (waitCount == WAIT_LAST) begin
                        // Engine never answered: flag it and end the frame
                        // exactly as the last result handshake would.
                        error          <= 1'b1;
                        autocorrMuxSel <= 1'b1;
                        if (run) begin
                            state       <= LOAD;
                            sampleReady <= 1'b1;
                            sampleCount <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
`endif
                end

                READ: begin
                    // Address has been stable since READ entry; memIn is
                    // settled once RD_LAT cycles have elapsed.
                    if (latCount == LAT_LAST) begin
                        rOut   <= memIn;
                        rIndex <= idx;
                        rValid <= 1'b1;
                        state  <= OUT;
                    end else begin
                        latCount <= latCount + 1'b1;
                    end
                end

                OUT: begin
                    if (rReady) begin
                        rValid <= 1'b0;
                        if (idx != IDX_LAST) begin
                            idx               <= idx + 4'd1;
                            latCount          <= '0;
                            testReadRequested <= R_BASE + 12'(idx) + 12'd1;
                            state             <= READ;
                        end else if (run) begin
                            state       <= LOAD;
                            sampleReady <= 1'b1;
                            sampleCount <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_autocorr_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_autocorr_frame_seq
//
// Self-checking bench for autocorr_frame_seq. The bench drives random samples
// and models the engine (`done` a fixed delay after `start`) and the
// result memory (read data RD_LAT cycles after the address). Each write and
// result is compared against a transaction-level reference model.
// Define AUTOCORR_SEQ_TIMEOUT_EN for both files to cover the watchdog.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_autocorr_frame_seq;

    localparam int          FRAME_LEN   = 240;
    localparam int          NUM_R       = 11;
    localparam logic [11:0] R_BASE      = 12'h0A0;
    localparam int          RD_LAT      = 2;
    localparam int          TIMEOUT_CYC = 4096;
    localparam int          DONE_DELAY  = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic        sampleReady;
    logic [7:0]  xMemAddr;
    logic [31:0] xMemOut;
    logic        xMemEn;
    logic        autocorrMuxSel;
    logic        start;
    logic        done;
    logic [11:0] testReadRequested;
    logic [31:0] memIn;
    logic [31:0] rOut;
    logic [3:0]  rIndex;
    logic        rValid;
    logic        rReady;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    autocorr_frame_seq #(
        .FRAME_LEN  (FRAME_LEN),
        .NUM_R      (NUM_R),
        .R_BASE     (R_BASE),
        .RD_LAT     (RD_LAT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .sampleIn         (sampleIn),
        .sampleValid      (sampleValid),
        .sampleReady      (sampleReady),
        .xMemAddr         (xMemAddr),
        .xMemOut          (xMemOut),
        .xMemEn           (xMemEn),
        .autocorrMuxSel   (autocorrMuxSel),
        .start            (start),
        .done             (done),
        .testReadRequested(testReadRequested),
        .memIn            (memIn),
        .rOut             (rOut),
        .rIndex           (rIndex),
        .rValid           (rValid),
        .rReady           (rReady),
        .busy             (busy),
        .error            (error)
    );

    // ---------------- result memory model: r[i] = {salt, 0x1000 + i} --------
    logic [11:0] rdPipe [RD_LAT];
    logic [15:0] salt;   // bumped per frame so stale words are detectable

    always @(posedge clk) begin
        rdPipe[0] <= testReadRequested;
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign memIn = {salt, 16'h1000 + 16'(rdPipe[RD_LAT-1] - R_BASE)};

    // ---------------- reference model state ----------------------------------
    int          checks, errors;
    int          cycle;
    logic [31:0] expData [$];   // sign-extended samples awaiting their write
    int          expAddr;       // writes seen in this frame
    int          accepted;      // handshakes issued in this frame
    int          expIdx;        // next result index expected
    int          framesDone, results, startCount;
    int          startTick, doneTick, lastAcceptTick;
    int          doneTimer, doneDelay;
    bit          prevStart, holding, expectResume, runAtAccept;
    logic [31:0] heldOut;
    logic [3:0]  heldIdx;
    bit          validRandom, readyRandom, stallOn;
    int          stallLeft;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic checkResetValues();
        check("rstSampleReady", sampleReady, 0);
        check("rstXMemAddr", xMemAddr, 0);
        check("rstXMemOut", xMemOut, 0);
        check("rstXMemEn", xMemEn, 0);
        check("rstMuxSel", autocorrMuxSel, 1);
        check("rstStart", start, 0);
        check("rstRdAddr", testReadRequested, 0);
        check("rstROut", rOut, 0);
        check("rstRIndex", rIndex, 0);
        check("rstRValid", rValid, 0);
        check("rstBusy", busy, 0);
        check("rstError", error, 0);
    endtask

    task automatic resetModel();
        expData.delete();
        expAddr = 0; accepted = 0; expIdx = 0;
        doneTimer = 0; done = 1'b0;
        prevStart = 0; holding = 0; expectResume = 0; stallLeft = 0;
    endtask

    // One clock: observe outputs at the falling edge, then drive the inputs
    // that the next rising edge will sample.
    task automatic tick();
        int          s;
        logic [31:0] expW;
        logic [31:0] expR;
        @(negedge clk);
        cycle++;
        if (reset) begin
            if (expectResume) begin
                check("resumeReady", sampleReady, runAtAccept);
                check("resumeBusy", busy, runAtAccept);
                expectResume = 0;
            end

            if (xMemEn) begin
                expW = (expData.size() != 0) ? expData.pop_front() : 32'hDEAD_BEEF;
                check("wrAddr", xMemAddr, expAddr);
                check("wrData", xMemOut, expW);
                expAddr++;
            end

            if (start) begin
                check("startMux", autocorrMuxSel, 0);
                check("startPrev", prevStart, 0);
                check("frameWrites", expAddr, FRAME_LEN);
                check("wrLeftover", expData.size(), 0);
                check("startErr", error, 0);
                startCount++;
                startTick = cycle;
                expAddr = 0; accepted = 0;
                salt++;
                done = 1'b0;
                doneTimer = doneDelay;
            end else if (doneTimer > 0) begin
                doneTimer--;
                if (doneTimer == 0) begin
                    done = 1'b1;
                    doneTick = cycle;
                end
            end
            prevStart = start;

            if (rValid) begin
                if (holding) begin
                    check("holdOut", rOut, heldOut);
                    check("holdIdx", rIndex, heldIdx);
                end else begin
                    expR = {salt, 16'h1000 + 16'(expIdx)};
                    check("rIndex", rIndex, expIdx);
                    check("rOut", rOut, expR);
                    check("rdAddr", testReadRequested, R_BASE + 12'(expIdx));
                    check("rdMux", autocorrMuxSel, 1);
                    if (expIdx == 0) check("doneToValid", cycle - doneTick, RD_LAT + 2);
                    else             check("readToValid", cycle - lastAcceptTick, RD_LAT + 2);
                    heldOut = expR;
                    heldIdx = 4'(expIdx);
                    if (stallOn && expIdx == 3) stallLeft = 20;
                end
            end
        end

        // Drive stimulus for the next rising edge.
        sampleValid = validRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
        case ($urandom_range(0, 7))
            0:       sampleIn = 16'h8000;
            1:       sampleIn = 16'h7FFF;
            default: sampleIn = 16'($urandom);
        endcase
        if (stallLeft > 0) begin
            rReady = 1'b0;
            stallLeft--;
        end else begin
            rReady = readyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        if (reset) begin
            if (sampleValid && sampleReady) begin
                s = $signed(sampleIn);
                expData.push_back(32'(s));
                accepted++;
            end
            if (rValid && rReady) begin
                results++;
                lastAcceptTick = cycle;
                expIdx++;
                if (expIdx == NUM_R) begin
                    expIdx = 0;
                    framesDone++;
                    expectResume = 1;
                    runAtAccept = run;
                end
            end
            holding = rValid && !rReady;
        end
    endtask

    task automatic waitFrames(input int target);
        int budget = 20000;
        while (framesDone < target && budget > 0) begin
            tick();
            budget--;
        end
        check("framesReached", framesDone, target);
    endtask

    task automatic waitAccepted(input int n);
        int budget = 5000;
        while (accepted < n && budget > 0) begin
            tick();
            budget--;
        end
        check("acceptReached", accepted, n);
    endtask

    int r0, s0, t0, r1;

    initial begin
        checks = 0; errors = 0; cycle = 0;
        framesDone = 0; results = 0; startCount = 0;
        startTick = 0; doneTick = 0; lastAcceptTick = 0;
        salt = 16'h0000;
        doneDelay = DONE_DELAY;
        validRandom = 0; readyRandom = 0; stallOn = 0;
        reset = 1'b0; run = 1'b1;
        sampleValid = 1'b1; sampleIn = '0; rReady = 1'b1;
        resetModel();

        // Reset held with run high and samples streaming.
        repeat (3) tick();
        checkResetValues();
        reset = 1'b1;

        // Five back-to-back frames: continuous, stalled r[3], then random.
        r0 = results;
        waitFrames(1);
        stallOn = 1; validRandom = 1;
        waitFrames(2);
        stallOn = 0; readyRandom = 1;
        waitFrames(5);
        check("fiveFrameResults", results - r0, 5 * NUM_R);

        // run falls mid-LOAD: the frame still completes, then IDLE.
        readyRandom = 0; validRandom = 0;
        waitAccepted(50);
        run = 1'b0;
        waitFrames(6);
        s0 = startCount;
        repeat (20) tick();
        check("idleBusy", busy, 0);
        check("idleReady", sampleReady, 0);
        check("idleNoStart", startCount, s0);

        // Restart; reset lands at sample 100 of the second frame.
        run = 1'b1;
        validRandom = 1;
        waitFrames(7);
        waitAccepted(100);
        reset = 1'b0;
        #1;
        checkResetValues();
        resetModel();
        repeat (2) tick();
        reset = 1'b1;
        waitFrames(8);

`ifdef AUTOCORR_SEQ_TIMEOUT_EN
        // Engine never answers: watchdog ends the frame without results.
        validRandom = 0;
        doneDelay = -1;
        s0 = startCount;
        begin
            int budget = 3000;
            while (startCount == s0 && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("toStart", startCount, s0 + 1);
        t0 = startTick;
        r1 = results;
        while (error !== 1'b1 && (cycle - t0) < TIMEOUT_CYC + 50) tick();
        check("toLatency", cycle - t0, TIMEOUT_CYC + 1);
        check("toReady", sampleReady, 1);
        check("toNoValid", results, r1);
        tick();
        check("toErrorClear", error, 0);
        doneDelay = DONE_DELAY;
        waitFrames(framesDone + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
